// File: rtl/dm_hart_array_ctrl.sv
// dm_hart_array_ctrl
//   Run-control engine for the debug module. It covers NrHarts harts and
//   supports group selection through the hart array mask (hasel/hawindow).
//   Each hart has its own small FSM (RUNNING/HALTREQ/HALTED/RESUMING) that
//   tracks the halt/resume handshake with the debug memory. Each hart also
//   keeps sticky havereset and halt-timeout flags. The block produces the
//   dmstatus any/all summary bits over the currently selected harts.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   dmactive_i             low = synchronous clear of all state
//   hartsel_i              dmcontrol hartsel (20 bit)
//   hasel_i, hawindow_i    hart array mask enable / window
//   haltreq_i              halt request level
//   resumereq_i            resume request pulse
//   ackhavereset_i         clears havereset of the selected harts
//   clear_timeout_i        clears timeout flags of the selected harts
//   hart_reset_i           per-hart reset-occurred pulse
//   unavailable_i          per-hart unavailable level
//   halted_valid_i/_id_i   a hart wrote HALTED
//   resuming_valid_i/_id_i a hart wrote RESUMING
//   debug_req_o            per-hart debug request (state HALTREQ)
//   resume_o               per-hart resume flag (state RESUMING)
//   halted_o               per-hart halted (state HALTED)
//   havereset_o, timeout_o sticky per-hart flags
//   any*/all*              dmstatus summaries over the selected harts
//
// Handshake: halted_valid_i and resuming_valid_i are single-cycle strobes
// that carry an id. There is no back-pressure: a strobe is consumed in the
// cycle it is seen. A strobe whose id is out of range is dropped. A
// resuming strobe for a hart that is not in RESUMING is also dropped.
//
// Debug visibility: the per-hart state is held in r_state[h], which has
// type hart_state_e.

module dm_hart_array_ctrl #(
  parameter int unsigned           NrHarts         = 1,
  parameter logic [NrHarts-1:0]    SelectableHarts = {NrHarts{1'b1}},
  parameter int unsigned           HaltTimeout     = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               dmactive_i,
  input  logic [19:0]        hartsel_i,
  input  logic               hasel_i,
  input  logic [NrHarts-1:0] hawindow_i,
  input  logic               haltreq_i,
  input  logic               resumereq_i,
  input  logic               ackhavereset_i,
  input  logic               clear_timeout_i,
  input  logic [NrHarts-1:0] hart_reset_i,
  input  logic [NrHarts-1:0] unavailable_i,
  input  logic               halted_valid_i,
  input  logic [19:0]        halted_id_i,
  input  logic               resuming_valid_i,
  input  logic [19:0]        resuming_id_i,
  output logic [NrHarts-1:0] debug_req_o,
  output logic [NrHarts-1:0] resume_o,
  output logic [NrHarts-1:0] halted_o,
  output logic [NrHarts-1:0] havereset_o,
  output logic [NrHarts-1:0] timeout_o,
  output logic               anyhalted_o,
  output logic               allhalted_o,
  output logic               anyrunning_o,
  output logic               allrunning_o,
  output logic               anyresumeack_o,
  output logic               allresumeack_o,
  output logic               anyhavereset_o,
  output logic               allhavereset_o,
  output logic               anyunavail_o,
  output logic               allunavail_o,
  output logic               anynonexistent_o,
  output logic               allnonexistent_o
);

  localparam int unsigned CW = (HaltTimeout < 1) ? 1 : $clog2(HaltTimeout + 1);
  // Last count value before the pending halt request is abandoned.
  localparam logic [CW-1:0] CntLast = (HaltTimeout == 0) ? '0 : CW'(HaltTimeout - 1);

  typedef enum logic [1:0] {
    ST_RUNNING  = 2'd0,
    ST_HALTREQ  = 2'd1,
    ST_HALTED   = 2'd2,
    ST_RESUMING = 2'd3
  } hart_state_e;

  hart_state_e        r_state [NrHarts];
  logic [CW-1:0]      r_cnt   [NrHarts];
  logic [NrHarts-1:0] r_resumeack;
  logic [NrHarts-1:0] r_havereset;
  logic [NrHarts-1:0] r_timeout;

  hart_state_e        w_state_nxt [NrHarts];
  logic [CW-1:0]      w_cnt_nxt   [NrHarts];
  logic [NrHarts-1:0] w_resumeack_nxt;
  logic [NrHarts-1:0] w_havereset_nxt;
  logic [NrHarts-1:0] w_timeout_nxt;

  logic [NrHarts-1:0] w_onehot;
  logic [NrHarts-1:0] w_sel;
  logic               w_present;
  logic               w_nonexist;

  // ---------------------------------------------------------------------
  // Selection. A hartsel that is out of range matches no loop index, so it
  // gives an all-zero onehot and reads as not present.
  // ---------------------------------------------------------------------
  always_comb begin
    w_onehot  = '0;
    w_present = 1'b0;
    for (int h = 0; h < NrHarts; h++) begin
      if (hartsel_i == 20'(h)) begin
        w_onehot[h] = 1'b1;
        w_present   = SelectableHarts[h];
      end
    end
    w_sel      = ((hasel_i ? hawindow_i : '0) | w_onehot) & SelectableHarts;
    w_nonexist = ~w_present;
  end

  // ---------------------------------------------------------------------
  // Per-hart next state. The events are taken in priority order. The
  // timeout flag is set by this FSM. Both sticky flags give priority to
  // setting over clearing.
  // ---------------------------------------------------------------------
  always_comb begin
    for (int h = 0; h < NrHarts; h++) begin
      w_state_nxt[h]     = r_state[h];
      w_cnt_nxt[h]       = r_cnt[h];
      w_resumeack_nxt[h] = r_resumeack[h];
      w_timeout_nxt[h]   = r_timeout[h] & ~(clear_timeout_i & w_sel[h]);
      w_havereset_nxt[h] = hart_reset_i[h] | (r_havereset[h] & ~(ackhavereset_i & w_sel[h]));

      if (unavailable_i[h]) begin
        w_state_nxt[h] = ST_RUNNING;
        w_cnt_nxt[h]   = '0;
      end else if (halted_valid_i && (halted_id_i == 20'(h))) begin
        w_state_nxt[h] = ST_HALTED;
        w_cnt_nxt[h]   = '0;
      end else if (resuming_valid_i && (resuming_id_i == 20'(h)) &&
                   (r_state[h] == ST_RESUMING)) begin
        w_state_nxt[h]     = ST_RUNNING;
        w_resumeack_nxt[h] = 1'b1;
      end else begin
        unique case (r_state[h])
          ST_HALTREQ: begin
            if (!haltreq_i || !w_sel[h]) begin
              w_state_nxt[h] = ST_RUNNING;
            end else if ((HaltTimeout != 0) && (r_cnt[h] == CntLast)) begin
              w_state_nxt[h]   = ST_RUNNING;
              w_timeout_nxt[h] = 1'b1;
            end else begin
              w_cnt_nxt[h] = r_cnt[h] + 1'b1;
            end
          end
          ST_RUNNING: begin
            // A hart that has timed out is not re-requested until its flag is cleared.
            if (haltreq_i && w_sel[h] && !r_timeout[h]) begin
              w_state_nxt[h] = ST_HALTREQ;
              w_cnt_nxt[h]   = '0;
            end
          end
          ST_HALTED: begin
            if (resumereq_i && w_sel[h] && !haltreq_i) begin
              w_state_nxt[h]     = ST_RESUMING;
              w_resumeack_nxt[h] = 1'b0;
            end
          end
          default: ; // RESUMING waits for the hart's RESUMING strobe
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int h = 0; h < NrHarts; h++) begin
        r_state[h] <= ST_RUNNING;
        r_cnt[h]   <= '0;
      end
      r_resumeack <= '1;
      r_havereset <= '1;
      r_timeout   <= '0;
    end else if (!dmactive_i) begin
      for (int h = 0; h < NrHarts; h++) begin
        r_state[h] <= ST_RUNNING;
        r_cnt[h]   <= '0;
      end
      r_resumeack <= '1;
      r_havereset <= '1;
      r_timeout   <= '0;
    end else begin
      for (int h = 0; h < NrHarts; h++) begin
        r_state[h] <= w_state_nxt[h];
        r_cnt[h]   <= w_cnt_nxt[h];
      end
      r_resumeack <= w_resumeack_nxt;
      r_havereset <= w_havereset_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Per-hart outputs and summary vectors (all taken from registers)
  // ---------------------------------------------------------------------
  logic [NrHarts-1:0] w_halted_v;
  logic [NrHarts-1:0] w_running_v;
  logic [NrHarts-1:0] w_resumeack_v;

  always_comb begin
    for (int h = 0; h < NrHarts; h++) begin
      debug_req_o[h] = (r_state[h] == ST_HALTREQ);
      resume_o[h]    = (r_state[h] == ST_RESUMING);
      halted_o[h]    = (r_state[h] == ST_HALTED);
      w_halted_v[h]  = (r_state[h] == ST_HALTED) & ~unavailable_i[h];
      w_running_v[h] = ((r_state[h] == ST_RUNNING) || (r_state[h] == ST_HALTREQ)) &
                       ~unavailable_i[h];
    end
    w_resumeack_v = r_resumeack & ~unavailable_i;
  end

  assign havereset_o = r_havereset;
  assign timeout_o   = r_timeout;

  // "all" has to be forced low when nothing is selected.
  logic w_any_sel;
  assign w_any_sel = |w_sel;

  assign anyhalted_o      = |(w_halted_v & w_sel);
  assign allhalted_o      = w_any_sel & (&(w_halted_v | ~w_sel));
  assign anyrunning_o     = |(w_running_v & w_sel);
  assign allrunning_o     = w_any_sel & (&(w_running_v | ~w_sel));
  assign anyresumeack_o   = |(w_resumeack_v & w_sel);
  assign allresumeack_o   = w_any_sel & (&(w_resumeack_v | ~w_sel));
  assign anyhavereset_o   = |(r_havereset & w_sel);
  assign allhavereset_o   = w_any_sel & (&(r_havereset | ~w_sel));
  assign anyunavail_o     = |(unavailable_i & w_sel);
  assign allunavail_o     = w_any_sel & (&(unavailable_i | ~w_sel));
  assign anynonexistent_o = w_nonexist;
  assign allnonexistent_o = w_nonexist & ~w_any_sel;

endmodule

// File: tb/tb_dm_hart_array_ctrl.sv
module tb_dm_hart_array_ctrl;

  localparam int N = 4;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          dmactive, hasel, haltreq, resumereq, ackhavereset, clear_timeout;
  logic [19:0]   hartsel, halted_id, resuming_id;
  logic [N-1:0]  hawindow, hart_reset, unavailable;
  logic          halted_valid, resuming_valid;
  logic [N-1:0]  debug_req, resume, halted, havereset, timeout;
  logic          anyhalted, allhalted, anyrunning, allrunning, anyresumeack, allresumeack;
  logic          anyhavereset, allhavereset, anyunavail, allunavail, anynonexistent, allnonexistent;

  dm_hart_array_ctrl #(
    .NrHarts(N), .SelectableHarts(4'b1111), .HaltTimeout(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive), .hartsel_i(hartsel),
    .hasel_i(hasel), .hawindow_i(hawindow), .haltreq_i(haltreq),
    .resumereq_i(resumereq), .ackhavereset_i(ackhavereset),
    .clear_timeout_i(clear_timeout), .hart_reset_i(hart_reset),
    .unavailable_i(unavailable), .halted_valid_i(halted_valid),
    .halted_id_i(halted_id), .resuming_valid_i(resuming_valid),
    .resuming_id_i(resuming_id), .debug_req_o(debug_req), .resume_o(resume),
    .halted_o(halted), .havereset_o(havereset), .timeout_o(timeout),
    .anyhalted_o(anyhalted), .allhalted_o(allhalted),
    .anyrunning_o(anyrunning), .allrunning_o(allrunning),
    .anyresumeack_o(anyresumeack), .allresumeack_o(allresumeack),
    .anyhavereset_o(anyhavereset), .allhavereset_o(allhavereset),
    .anyunavail_o(anyunavail), .allunavail_o(allunavail),
    .anynonexistent_o(anynonexistent), .allnonexistent_o(allnonexistent)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // Advance one clock. Outputs are sampled 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic halt_strobe(input int id);
    halted_valid = 1'b1; halted_id = 20'(id);
    step();
    halted_valid = 1'b0;
  endtask

  task automatic resuming_strobe(input int id);
    resuming_valid = 1'b1; resuming_id = 20'(id);
    step();
    resuming_valid = 1'b0;
  endtask

  task automatic resume_pulse();
    resumereq = 1'b1;
    step();
    resumereq = 1'b0;
  endtask

  int hi_cnt;

  initial begin
    dmactive = 1'b1; hasel = 1'b0; haltreq = 1'b0; resumereq = 1'b0;
    ackhavereset = 1'b0; clear_timeout = 1'b0; hartsel = '0;
    halted_id = '0; resuming_id = '0; hawindow = '0; hart_reset = '0;
    unavailable = '0; halted_valid = 1'b0; resuming_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    // Reset state, with hart 0 selected
    check_val("rst_debug_req", 32'(debug_req), 32'h0);
    check_val("rst_resume", 32'(resume), 32'h0);
    check_val("rst_halted", 32'(halted), 32'h0);
    check_val("rst_havereset", 32'(havereset), 32'hF);
    check_val("rst_timeout", 32'(timeout), 32'h0);
    check_val("rst_summary", {20'b0, anyhalted, allhalted, anyrunning, allrunning,
              anyresumeack, allresumeack, anyhavereset, allhavereset, anyunavail,
              allunavail, anynonexistent, allnonexistent}, 32'b0011_1111_0000);
    @(negedge clk); rst_n = 1'b1;
    #1;

    // Clear havereset on every hart through the window
    hasel = 1'b1; hawindow = 4'hF; ackhavereset = 1'b1;
    step();
    ackhavereset = 1'b0; hasel = 1'b0; hawindow = '0;
    check_val("ack_all_havereset", 32'(havereset), 32'h0);

    // Single-hart halt
    hartsel = 20'd2; haltreq = 1'b1;
    step();
    check_val("t1_debug_req", 32'(debug_req), 32'h4);
    halt_strobe(2);
    check_val("t1_debug_req_drop", 32'(debug_req), 32'h0);
    check_val("t1_halted", 32'(halted), 32'h4);
    check_val("t1_any_all_halted", {30'b0, anyhalted, allhalted}, 32'h3);
    // A resume request while haltreq is still high is ignored
    resume_pulse();
    check_val("t1_resume_blocked", 32'(resume), 32'h0);
    haltreq = 1'b0;

    // Resume handshake
    resume_pulse();
    check_val("t2_resume", 32'(resume), 32'h4);
    check_val("t2_anyresumeack", 32'(anyresumeack), 32'h0);
    resuming_strobe(2);
    check_val("t2_resume_drop", 32'(resume), 32'h0);
    check_val("t2_ack_running", {30'b0, allresumeack, allrunning}, 32'h3);

    // Group halt through the hart array window
    hasel = 1'b1; hawindow = 4'b1011; hartsel = 20'd0; haltreq = 1'b1;
    step();
    check_val("t3_debug_req", 32'(debug_req), 32'hB);
    halt_strobe(0);
    halt_strobe(1);
    check_val("t3_halted", 32'(halted), 32'h3);
    check_val("t3_debug_req_h3", 32'(debug_req), 32'h8);
    check_val("t3_any_all_halted", {30'b0, anyhalted, allhalted}, 32'h2);
    // Hart 3 becomes unavailable while in HALTREQ
    unavailable = 4'b1000;
    step();
    check_val("t3_unavail_dreq", 32'(debug_req), 32'h0);
    check_val("t3_unavail_sum", {30'b0, anyunavail, allunavail}, 32'h2);
    unavailable = '0; haltreq = 1'b0;
    step();
    resume_pulse();
    check_val("t3_resume", 32'(resume), 32'h3);
    resuming_strobe(0);
    resuming_strobe(1);
    check_val("t3_resume_done", 32'(resume), 32'h0);
    check_val("t3_allresumeack", 32'(allresumeack), 32'h1);
    hasel = 1'b0; hawindow = '0;

    // Halt timeout: with no HALTED strobe, debug_req stays high for 8 cycles
    hartsel = 20'd1; haltreq = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (debug_req[1]) hi_cnt++;
    end
    check_val("t4_req_cycles", 32'(hi_cnt), 32'd8);
    check_val("t4_timeout", 32'(timeout), 32'h2);
    check_val("t4_no_rereq", 32'(debug_req), 32'h0);
    clear_timeout = 1'b1;
    step();
    clear_timeout = 1'b0;
    check_val("t4_timeout_clr", 32'(timeout), 32'h0);
    step();
    check_val("t4_rereq", 32'(debug_req), 32'h2);
    haltreq = 1'b0;
    step();
    check_val("t4_req_drop", 32'(debug_req), 32'h0);

    // Nonexistent hart
    hartsel = 20'd7;
    #1;
    check_val("t5_nonexist", {30'b0, anynonexistent, allnonexistent}, 32'h3);
    check_val("t5_sel0_sum", {30'b0, anyhalted, allrunning}, 32'h0);
    haltreq = 1'b1;
    step();
    check_val("t5_no_req", 32'(debug_req), 32'h0);
    haltreq = 1'b0;
    // havereset: a set and an ack in the same cycle leave the flag set
    hartsel = 20'd1; hart_reset = 4'b0010; ackhavereset = 1'b1;
    step();
    hart_reset = '0;
    check_val("t5_set_wins", 32'(havereset), 32'h2);
    step();
    ackhavereset = 1'b0;
    check_val("t5_ack_clr", 32'(havereset), 32'h0);

    // dmactive low clears all state synchronously
    hartsel = 20'd0; haltreq = 1'b1;
    step();
    halt_strobe(0);
    haltreq = 1'b0;
    check_val("t6_halted", 32'(halted), 32'h1);
    dmactive = 1'b0;
    step();
    dmactive = 1'b1;
    check_val("t6_dmact_halted", 32'(halted), 32'h0);
    check_val("t6_dmact_havereset", 32'(havereset), 32'hF);

    // Asynchronous reset while a hart is in RESUMING
    hartsel = 20'd2; haltreq = 1'b1;
    step();
    halt_strobe(2);
    haltreq = 1'b0;
    resume_pulse();
    check_val("t6_resuming", 32'(resume), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    check_val("t6_arst_resume", 32'(resume), 32'h0);
    check_val("t6_arst_halted", 32'(halted), 32'h0);
    check_val("t6_arst_dreq", 32'(debug_req), 32'h0);
    check_val("t6_arst_havereset", 32'(havereset), 32'hF);
    @(negedge clk); rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
